// File: rtl/compressor_pkg.sv
// Shared constants and elaboration-time helpers for the 3:2 carry-save reduction tree.
// Contents:
//   terms_after_level(n, lvl) - operand count left after lvl compressor levels
//   num_levels(n)             - compressor levels needed to reach two operands
//   num_stages(levels, lps)   - register stages for lps levels per stage
// The per-stage record {valid, tag, terms} depends on the module parameters, so the
// top builds it from a per-stage valid/tag shift chain plus sized data registers.
package compressor_pkg;

    // Each level turns every full triple into (sum, carry); leftovers pass through.
    function automatic int unsigned terms_after_level(input int unsigned n,
                                                      input int unsigned lvl);
        int unsigned t;
        t = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            t = (t / 3) * 2 + (t % 3);
        end
        return t;
    endfunction

    function automatic int unsigned num_levels(input int unsigned n);
        int unsigned t;
        int unsigned lv;
        t  = n;
        lv = 0;
        while (t > 2) begin
            t  = (t / 3) * 2 + (t % 3);
            lv = lv + 1;
        end
        return lv;
    endfunction

    function automatic int unsigned num_stages(input int unsigned levels,
                                               input int unsigned lps);
        return (levels + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/compressor_tree_3_to_2_pipe_if.sv
// Handshake bus for compressor_tree_3_to_2_pipe.
// Upstream:   in_valid, in_ready, terms[NUM_ELEMENTS], in_tag
// Downstream: out_valid, out_ready, C, S, out_tag (+ sum when
//             COMPRESSOR_TREE_FINAL_ADD_EN is defined)
// master = producer/consumer side (testbench or datapath), slave = tree.
interface compressor_tree_3_to_2_pipe_if #(
    parameter int unsigned NUM_ELEMENTS = 9,
    parameter int unsigned BIT_LEN      = 16,
    parameter int unsigned OUT_LEN      = BIT_LEN + $clog2(NUM_ELEMENTS),
    parameter int unsigned TAG_W        = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [BIT_LEN-1:0]  terms [NUM_ELEMENTS];
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_LEN-1:0]  C;
    logic [OUT_LEN-1:0]  S;
    logic [TAG_W-1:0]    out_tag;
`ifdef COMPRESSOR_TREE_FINAL_ADD_EN
    logic [OUT_LEN-1:0]  sum;

    modport master (output in_valid, terms, in_tag, out_ready,
                    input  in_ready, out_valid, C, S, out_tag, sum);
    modport slave  (input  in_valid, terms, in_tag, out_ready,
                    output in_ready, out_valid, C, S, out_tag, sum);
`else
    modport master (output in_valid, terms, in_tag, out_ready,
                    input  in_ready, out_valid, C, S, out_tag);
    modport slave  (input  in_valid, terms, in_tag, out_ready,
                    output in_ready, out_valid, C, S, out_tag);
`endif
endinterface

// File: rtl/compressor_3_to_2_level.sv
// One combinational level of 3:2 compressors.
// Ports:
//   i_terms   [N_IN]  operands of WIDTH bits
//   o_terms_c [N_OUT] reduced operands; for triple g: [2g]=sum, [2g+1]=carry<<1,
//                     followed by the 0..2 leftover operands unchanged
module compressor_3_to_2_level
    import compressor_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_OUT = terms_after_level(N_IN, 1)
) (
    input  logic [WIDTH-1:0] i_terms   [N_IN],
    output logic [WIDTH-1:0] o_terms_c [N_OUT]
);
    localparam int unsigned N_GRP = N_IN / 3;
    localparam int unsigned N_REM = N_IN % 3;

    // Full adders per bit column; carry moves up one weight and drops the MSB.
    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        logic [WIDTH-1:0] w_maj;
        assign w_maj = (i_terms[3*g] & i_terms[3*g+1])
                     | (i_terms[3*g] & i_terms[3*g+2])
                     | (i_terms[3*g+1] & i_terms[3*g+2]);
        assign o_terms_c[2*g]   = i_terms[3*g] ^ i_terms[3*g+1] ^ i_terms[3*g+2];
        assign o_terms_c[2*g+1] = {w_maj[WIDTH-2:0], 1'b0};
    end

    for (genvar r = 0; r < N_REM; r++) begin : g_rem
        assign o_terms_c[2*N_GRP+r] = i_terms[3*N_GRP+r];
    end

endmodule

// File: rtl/compressor_tree_3_to_2_pipe.sv
// Pipelined carry-save reduction tree: NUM_ELEMENTS operands -> redundant (C, S).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of compressor_tree_3_to_2_pipe_if
// Optional feature macro COMPRESSOR_TREE_FINAL_ADD_EN: adds one register stage
// producing bus.sum = C + S, with C/S/out_tag delayed to stay aligned.
// All stages advance together on adv = out_ready | ~out_valid; bubbles are kept.
module compressor_tree_3_to_2_pipe
    import compressor_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS     = 9,
    parameter int unsigned BIT_LEN          = 16,
    parameter int unsigned OUT_LEN          = BIT_LEN + $clog2(NUM_ELEMENTS),
    parameter int unsigned LEVELS_PER_STAGE = 1,
    parameter int unsigned TAG_W            = 4
) (
    input  logic clk,
    input  logic rst_n,
    compressor_tree_3_to_2_pipe_if.slave bus
);
    localparam int unsigned LEVELS = num_levels(NUM_ELEMENTS);
    localparam int unsigned STAGES = num_stages(LEVELS, LEVELS_PER_STAGE);
`ifdef COMPRESSOR_TREE_FINAL_ADD_EN
    localparam int unsigned PIPE   = STAGES + 1;
`else
    localparam int unsigned PIPE   = STAGES;
`endif

    logic [PIPE-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag [PIPE];
    logic               w_adv;
    logic [OUT_LEN-1:0] w_ext [NUM_ELEMENTS];
    logic [OUT_LEN-1:0] w_last_s;
    logic [OUT_LEN-1:0] w_last_c;

    assign w_adv       = bus.out_ready | ~r_valid[PIPE-1];
    assign bus.in_ready = w_adv;
    assign bus.out_valid = r_valid[PIPE-1];
    assign bus.out_tag   = r_tag[PIPE-1];

    // Valid and tag travel as a shift chain in lock-step with the data stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_tag   <= '{default: '0};
        end else if (w_adv) begin
            r_valid[0] <= bus.in_valid;
            r_tag[0]   <= bus.in_tag;
            for (int unsigned i = 1; i < PIPE; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_ext
        assign w_ext[i] = OUT_LEN'(bus.terms[i]);
    end

    // One block per compressor level; a register closes every LEVELS_PER_STAGE
    // levels and always after the last level. w_q is what the next level sees.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned N_IN  = terms_after_level(NUM_ELEMENTS, l);
        localparam int unsigned N_OUT = terms_after_level(NUM_ELEMENTS, l + 1);
        localparam bit          REG_OUT = (((l + 1) % LEVELS_PER_STAGE) == 0)
                                       || (l == LEVELS - 1);

        logic [OUT_LEN-1:0] w_in  [N_IN];
        logic [OUT_LEN-1:0] w_out [N_OUT];
        logic [OUT_LEN-1:0] w_q   [N_OUT];

        if (l == 0) begin : g_src_in
            for (genvar i = 0; i < N_IN; i++) begin : g_in
                assign w_in[i] = w_ext[i];
            end
        end else begin : g_src_prev
            for (genvar i = 0; i < N_IN; i++) begin : g_in
                assign w_in[i] = g_lvl[l-1].w_q[i];
            end
        end

        compressor_3_to_2_level #(
            .N_IN  (N_IN),
            .WIDTH (OUT_LEN)
        ) u_level (
            .i_terms   (w_in),
            .o_terms_c (w_out)
        );

        if (REG_OUT) begin : g_reg
            logic [OUT_LEN-1:0] r_data [N_OUT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '{default: '0};
                end else if (w_adv) begin
                    r_data <= w_out;
                end
            end

            assign w_q = r_data;
        end else begin : g_comb
            assign w_q = w_out;
        end
    end

    // The final level is always a single 3:2, so lane 0 is sum and lane 1 carry.
    assign w_last_s = g_lvl[LEVELS-1].w_q[0];
    assign w_last_c = g_lvl[LEVELS-1].w_q[1];

`ifdef COMPRESSOR_TREE_FINAL_ADD_EN
    logic [OUT_LEN-1:0] r_fa_c;
    logic [OUT_LEN-1:0] r_fa_s;
    logic [OUT_LEN-1:0] r_fa_sum;

    // Carry-propagate stage; C/S are re-registered so they stay aligned with sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fa_c   <= '0;
            r_fa_s   <= '0;
            r_fa_sum <= '0;
        end else if (w_adv) begin
            r_fa_c   <= w_last_c;
            r_fa_s   <= w_last_s;
            r_fa_sum <= w_last_c + w_last_s;
        end
    end

    assign bus.C   = r_fa_c;
    assign bus.S   = r_fa_s;
    assign bus.sum = r_fa_sum;
`else
    assign bus.C = w_last_c;
    assign bus.S = w_last_s;
`endif

endmodule
